// File: rtl/onehot_event_encoder.sv
// onehot_event_encoder: captures one-hot event requests on four lines into
// sticky pending flags and serializes them as 2-bit codes over a valid/ready
// output handshake. Arbitration is round-robin (RR_EN=1) or fixed priority
// with line 0 highest (RR_EN=0). Lost events are recorded in sticky overrun
// flags that clear on a clr_ovr pulse.
module onehot_event_encoder #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       clr_ovr,
  input  logic       out_ready,
  output logic [1:0] out_code,
  output logic       out_valid,
  output logic [3:0] pending,
  output logic [3:0] overrun,
  output logic       busy
);

  logic [1:0] rr_ptr;
  logic [1:0] scan_start;
  logic [1:0] scan_idx;
  logic [1:0] sel_idx;
  logic       load;
  logic       drain;
  logic [3:0] sel_onehot;
  logic [3:0] pending_nxt;
  logic [3:0] ovr_set;
  logic [3:0] overrun_nxt;

  // Pick the first pending line scanning upward from the start point, mod 4.
  // The scan runs from the far end back so the nearest candidate is written last.
  always_comb begin
    sel_idx    = 2'd0;
    scan_idx   = 2'd0;
    scan_start = RR_EN ? rr_ptr : 2'd0;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = scan_start + 2'(k);
      if (pending[scan_idx]) sel_idx = scan_idx;
    end
  end

  // Load/drain decisions and next-state of the sticky flag vectors.
  // A line loaded in the same cycle it requests again keeps its pending bit
  // and is not counted as an overrun: the new event is simply retained.
  always_comb begin
    load        = (|pending) && (!out_valid || out_ready);
    drain       = out_valid && out_ready && !(|pending);
    sel_onehot  = load ? (4'b0001 << sel_idx) : 4'b0000;
    pending_nxt = (pending & ~sel_onehot) | req;
    ovr_set     = req & pending & ~sel_onehot;
    overrun_nxt = (clr_ovr ? 4'b0000 : overrun) | ovr_set;
  end

  // Sticky pending and overrun flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 4'b0000;
      overrun <= 4'b0000;
    end else begin
      pending <= pending_nxt;
      overrun <= overrun_nxt;
    end
  end

  // Output register: load a new code, or drop valid once the last code is taken.
  // out_code keeps its last value after a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_code  <= 2'd0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_code  <= sel_idx;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer advances past each loaded line; idle at 0 in fixed-priority mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 2'd0;
    end else if (RR_EN && load) begin
      rr_ptr <= sel_idx + 2'd1;
    end
  end

  // Activity indicator, derived from registers only.
  always_comb begin
    busy = (|pending) || out_valid;
  end

endmodule

// File: tb/tb_onehot_event_encoder.sv
// Testbench for onehot_event_encoder: directed stimulus with a scoreboard of
// expected codes, popped whenever a handshake completes.
module tb_onehot_event_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] req_fp = 4'b0000;
  logic       clr_ovr = 1'b0;
  logic       out_ready = 1'b0;

  logic [1:0] out_code, out_code_fp;
  logic       out_valid, out_valid_fp;
  logic [3:0] pending, pending_fp;
  logic [3:0] overrun, overrun_fp;
  logic       busy, busy_fp;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int exp_fp_q[$];

  always #5 clk = ~clk;

  onehot_event_encoder #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .clr_ovr(clr_ovr), .out_ready(out_ready),
    .out_code(out_code), .out_valid(out_valid), .pending(pending),
    .overrun(overrun), .busy(busy)
  );

  onehot_event_encoder #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req(req_fp), .clr_ovr(clr_ovr), .out_ready(out_ready),
    .out_code(out_code_fp), .out_valid(out_valid_fp), .pending(pending_fp),
    .overrun(overrun_fp), .busy(busy_fp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    exp_fp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Handshake completes at the next rising edge; sample on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("rr_extra_code", {31'b0, out_valid}, 32'd0);
        else check("rr_code", {30'b0, out_code}, exp_q.pop_front());
      end
      if (out_valid_fp && out_ready) begin
        if (exp_fp_q.size() == 0) check("fp_extra_code", {31'b0, out_valid_fp}, 32'd0);
        else check("fp_code", {30'b0, out_code_fp}, exp_fp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    #1;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_code", {30'b0, out_code}, 32'd0);
    check("rst_pending", {28'b0, pending}, 32'd0);
    check("rst_overrun", {28'b0, overrun}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    do_reset();

    // Single event latency
    out_ready = 1'b1;
    req = 4'b0100;
    exp_q.push_back(2);
    tick();
    req = 4'b0000;
    check("lat_pending", {28'b0, pending}, 32'h4);
    check("lat_valid_e1", {31'b0, out_valid}, 32'd0);
    tick();
    check("lat_valid_e2", {31'b0, out_valid}, 32'd1);
    check("lat_code_e2", {30'b0, out_code}, 32'd2);
    check("lat_ovr", {28'b0, overrun}, 32'd0);
    tick();
    check("lat_valid_e3", {31'b0, out_valid}, 32'd0);
    check("lat_ovr_end", {28'b0, overrun}, 32'd0);

    // All four lines at once, round-robin
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    req = 4'b1111;
    tick();
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("all4_valid", {31'b0, out_valid}, 32'd1);
      check("all4_code", {30'b0, out_code}, i);
    end
    tick();
    check("all4_drain", {31'b0, out_valid}, 32'd0);
    check("all4_rr_ptr", {30'b0, dut.rr_ptr}, 32'd0);

    // Two lines requesting continuously: round-robin vs fixed priority
    for (int i = 0; i < 9; i++) exp_q.push_back((i % 2 == 1) ? 3 : 0);
    for (int i = 0; i < 8; i++) exp_fp_q.push_back(0);
    exp_fp_q.push_back(3);
    req = 4'b1001;
    req_fp = 4'b1001;
    repeat (8) tick();
    req = 4'b0000;
    req_fp = 4'b0000;
    repeat (3) tick();
    check("alt_rr_idle", {31'b0, out_valid}, 32'd0);
    check("alt_fp_idle", {31'b0, out_valid_fp}, 32'd0);
    check("alt_rr_ovr", {28'b0, overrun}, 32'h9);
    check("alt_fp_ovr", {28'b0, overrun_fp}, 32'h8);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("alt_rr_clr", {28'b0, overrun}, 32'd0);
    check("alt_fp_clr", {28'b0, overrun_fp}, 32'd0);

    // Backpressure with a repeated event on line 1
    out_ready = 1'b0;
    exp_q.push_back(1);
    exp_q.push_back(1);
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    check("bp_valid", {31'b0, out_valid}, 32'd1);
    check("bp_code", {30'b0, out_code}, 32'd1);
    req = 4'b0010;
    tick();
    req = 4'b0000;
    check("bp_pending", {28'b0, pending}, 32'h2);
    check("bp_ovr_none", {28'b0, overrun}, 32'd0);
    tick();
    check("bp_code_hold", {30'b0, out_code}, 32'd1);
    req = 4'b0010;
    tick();
    req = 4'b0000;
    check("bp_ovr_set", {28'b0, overrun}, 32'h2);
    check("bp_code_hold2", {30'b0, out_code}, 32'd1);
    check("bp_busy", {31'b0, busy}, 32'd1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("bp_ovr_clr", {28'b0, overrun}, 32'd0);
    out_ready = 1'b1;
    repeat (3) tick();
    check("bp_drained", {31'b0, out_valid}, 32'd0);
    check("bp_pending_end", {28'b0, pending}, 32'd0);

    // Re-request on the cycle line 1 is loaded
    exp_q.push_back(1);
    exp_q.push_back(1);
    req = 4'b0010;
    tick();
    tick();
    req = 4'b0000;
    check("sim_pending", {28'b0, pending}, 32'h2);
    check("sim_ovr", {28'b0, overrun}, 32'd0);
    check("sim_code", {30'b0, out_code}, 32'd1);
    tick();
    check("sim_valid2", {31'b0, out_valid}, 32'd1);
    tick();
    check("sim_idle", {31'b0, out_valid}, 32'd0);

    // clr_ovr coinciding with a new overrun on line 0
    out_ready = 1'b0;
    exp_q.push_back(3);
    req = 4'b1000;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b1000;
    repeat (2) tick();
    req = 4'b0000;
    check("coin_ovr3", {28'b0, overrun}, 32'h8);
    req = 4'b0001;
    tick();
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    req = 4'b0000;
    check("coin_ovr", {28'b0, overrun}, 32'h1);

    // Asynchronous reset in the middle of a stall
    do_reset();
    out_ready = 1'b0;
    exp_q.push_back(0);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b1010;
    tick();
    req = 4'b0000;
    check("ar_pre_valid", {31'b0, out_valid}, 32'd1);
    check("ar_pre_pending", {28'b0, pending}, 32'hA);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("ar_valid", {31'b0, out_valid}, 32'd0);
    check("ar_code", {30'b0, out_code}, 32'd0);
    check("ar_pending", {28'b0, pending}, 32'd0);
    check("ar_busy", {31'b0, busy}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) tick();
    check("ar_post_valid", {31'b0, out_valid}, 32'd0);
    check("ar_post_busy", {31'b0, busy}, 32'd0);

    check("sb_rr_left", exp_q.size(), 32'd0);
    check("sb_fp_left", exp_fp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
